adc_spi_cfg: RTL and testbench

ADC_SPI_CFG -- requirements
Module: adc_spi_cfg

---
 rtl/adc_spi_cfg.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_spi_cfg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_cfg.sv
// adc_spi_cfg: power-up configuration sequencer for an ADC with a 3-wire
// SPI port (shared SDIO). It waits PWRUP_CYC cycles after reset, writes a
// fixed four-entry init table, then serves single host register writes.
//
// Optional build macro ADC_SPI_READBACK_EN: after the two data-bearing
// table writes (0x014, 0x00D), a read frame to the same address is issued.
// The returned byte is compared and any mismatch sets the sticky cfg_err.
// Without the macro, cfg_err is tied low and adc_sdio_i is ignored.
//
// Ports
//   clk_200m     sole clock
//   rst_n        async active-low reset; deassertion synchronised internally
//   wr_req       host frame request, held until wr_ack
//   wr_addr      13-bit ADC register address
//   wr_data      8-bit register write data
//   wr_ack       one-cycle accept pulse (only from IDLE, i.e. after init)
//   init_done    sticky, set on first entry into IDLE
//   busy         high whenever not in IDLE
//   cfg_err      sticky readback mismatch flag
//   adc_csb      chip select, active low
//   adc_sclk     SPI clock, idle low, half-period = CLK_DIV cycles
//   adc_sdio_o   serial data out, MSB first, changes after SCLK falls
//   adc_sdio_oe  SDIO drive enable (low = released)
//   adc_sdio_i   serial data in from the pad
module adc_spi_cfg #(
    parameter int CLK_DIV   = 4,
    parameter int PWRUP_CYC = 20000,
    parameter int GAP_CYC   = 8
) (
    input  logic        clk_200m,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        init_done,
    output logic        busy,
    output logic        cfg_err,
    output logic        adc_csb,
    output logic        adc_sclk,
    output logic        adc_sdio_o,
    output logic        adc_sdio_oe,
    input  logic        adc_sdio_i
);

`ifdef ADC_SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [2:0] {PWRUP, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP, IDLE} state_t;

    // Reset asserts immediately, releases two clocks after rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk_200m or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    state_t      state;
    logic [23:0] cnt;       // power-up and gap timer
    logic [7:0]  hc;        // SCLK half-period timer
    logic [4:0]  bit_cnt;   // SCLK rising edges seen in this frame
    logic [1:0]  idx;       // init table index
    logic        rd_phase;  // current table entry is in its readback frame
    logic        frame_rd;  // frame in flight is a read
    logic [23:0] shreg;
    logic [12:0] h_addr;
    logic [7:0]  h_data;

    function automatic logic [20:0] init_entry(input logic [1:0] i);
        case (i)
            2'd0:    return {13'h000, 8'h3C};  // soft reset
            2'd1:    return {13'h014, 8'h01};  // twos-complement output
            2'd2:    return {13'h00D, 8'h00};  // test pattern off
            default: return {13'h0FF, 8'h01};  // transfer
        endcase
    endfunction

    logic [20:0] tbl;
    logic        ld_rw;
    logic [12:0] ld_addr;
    logic [7:0]  ld_data;
    logic [23:0] frame;

    // Once init is done every frame is a host write; before that the
    // table entry (or its readback) is sent.
    always_comb begin
        tbl     = init_entry(idx);
        ld_rw   = 1'b0;
        ld_addr = h_addr;
        ld_data = h_data;
        if (!init_done) begin
            ld_rw   = rd_phase;
            ld_addr = tbl[20:8];
            ld_data = rd_phase ? 8'h00 : tbl[7:0];
        end
        frame = {ld_rw, 2'b00, ld_addr, ld_data};
    end

`ifdef ADC_SPI_READBACK_EN
    logic [7:0] rx;
    logic       cfg_err_q;
    assign cfg_err = cfg_err_q;
`else
    logic unused_sdio_i;
    assign unused_sdio_i = adc_sdio_i;
    assign cfg_err       = 1'b0;
`endif

    always_ff @(posedge clk_200m or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= PWRUP;
            cnt         <= '0;
            hc          <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            rd_phase    <= 1'b0;
            frame_rd    <= 1'b0;
            shreg       <= '0;
            h_addr      <= '0;
            h_data      <= '0;
            wr_ack      <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
            adc_csb     <= 1'b1;
            adc_sclk    <= 1'b0;
            adc_sdio_o  <= 1'b0;
            adc_sdio_oe <= 1'b0;
`ifdef ADC_SPI_READBACK_EN
            rx          <= '0;
            cfg_err_q   <= 1'b0;
`endif
        end else begin
            wr_ack <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt == 24'(PWRUP_CYC - 1)) begin
                        cnt      <= '0;
                        idx      <= '0;
                        rd_phase <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                LOAD: begin
                    shreg       <= frame;
                    adc_sdio_o  <= frame[23];
                    adc_csb     <= 1'b0;
                    adc_sdio_oe <= 1'b1;
                    frame_rd    <= ld_rw;
                    hc          <= '0;
                    state       <= CS_SETUP;
                end
                CS_SETUP: begin
                    // End of setup is the first SCLK rising edge.
                    if (hc == 8'(CLK_DIV - 1)) begin
                        hc       <= '0;
                        adc_sclk <= 1'b1;
                        bit_cnt  <= 5'd1;
                        state    <= SHIFT;
                    end else begin
                        hc <= hc + 8'd1;
                    end
                end
                SHIFT: begin
                    if (hc == 8'(CLK_DIV - 1)) begin
                        hc <= '0;
                        if (adc_sclk) begin
                            adc_sclk <= 1'b0;
                            if (bit_cnt == 5'd24) begin
                                state <= CS_HOLD;
`ifdef ADC_SPI_READBACK_EN
                                if (frame_rd && rx != tbl[7:0]) cfg_err_q <= 1'b1;
`endif
                            end else begin
                                shreg      <= {shreg[22:0], 1'b0};
                                adc_sdio_o <= shreg[22];
                                // Turn the bus around once address is out.
                                if (frame_rd && bit_cnt == 5'd16) adc_sdio_oe <= 1'b0;
                            end
                        end else begin
                            adc_sclk <= 1'b1;
                            bit_cnt  <= bit_cnt + 5'd1;
`ifdef ADC_SPI_READBACK_EN
                            if (frame_rd && bit_cnt >= 5'd16) rx <= {rx[6:0], adc_sdio_i};
`endif
                        end
                    end else begin
                        hc <= hc + 8'd1;
                    end
                end
                CS_HOLD: begin
                    if (hc == 8'(CLK_DIV - 1)) begin
                        hc          <= '0;
                        adc_csb     <= 1'b1;
                        adc_sdio_oe <= 1'b0;
                        adc_sdio_o  <= 1'b0;
                        cnt         <= '0;
                        state       <= GAP;
                    end else begin
                        hc <= hc + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 24'(GAP_CYC - 1)) begin
                        cnt <= '0;
                        if (init_done) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (READBACK && !rd_phase && (idx == 2'd1 || idx == 2'd2)) begin
                            rd_phase <= 1'b1;
                            state    <= LOAD;
                        end else if (idx == 2'd3) begin
                            rd_phase  <= 1'b0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                            init_done <= 1'b1;
                        end else begin
                            rd_phase <= 1'b0;
                            idx      <= idx + 2'd1;
                            state    <= LOAD;
                        end
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                IDLE: begin
                    if (wr_req) begin
                        wr_ack <= 1'b1;
                        h_addr <= wr_addr;
                        h_data <= wr_data;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg.sv
`timescale 1ns/100ps
module tb_adc_spi_cfg;

    localparam int CLK_DIV   = 4;
    localparam int PWRUP_CYC = 100;
    localparam int GAP_CYC   = 8;
`ifdef ADC_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk_200m = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wr_req   = 1'b0;
    logic [12:0] wr_addr  = '0;
    logic [7:0]  wr_data  = '0;
    logic        adc_sdio_i = 1'b0;   // register model: every readback returns 0x00
    logic        wr_ack, init_done, busy, cfg_err;
    logic        adc_csb, adc_sclk, adc_sdio_o, adc_sdio_oe;

    int errors = 0;
    int checks = 0;

    adc_spi_cfg #(.CLK_DIV(CLK_DIV), .PWRUP_CYC(PWRUP_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk_200m(clk_200m), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .init_done(init_done), .busy(busy),
        .cfg_err(cfg_err), .adc_csb(adc_csb), .adc_sclk(adc_sclk),
        .adc_sdio_o(adc_sdio_o), .adc_sdio_oe(adc_sdio_oe), .adc_sdio_i(adc_sdio_i)
    );

    always #2.5 clk_200m = ~clk_200m;

    // ---------------- bus monitor (samples on falling clk edge) ----------
    logic        p_csb = 1'b1, p_sclk = 1'b0, p_sdio = 1'b0, p_oe = 1'b0, p_done = 1'b0;
    logic [23:0] cur = '0;
    int          e = 0, nbits = 0, last_rise = -1, hi_run = 0;
    bit          frame_since_rel = 0, done_seen = 0;
    logic [23:0] obs_frame[$];
    int          obs_bits[$], fall_cyc[$], gaps[$], oe_drop[$];
    int          bad_period = 0, bad_sdio = 0, early_ack = 0, ack_cnt = 0;
    int          rst_rises = 0, abort_bits = -1, done_frames = 0, done_gap = 0;

    always @(negedge clk_200m) begin
        if (!rst_n) begin
            e = 0;
            if (!p_sclk && adc_sclk) rst_rises++;
            if (!p_csb && adc_csb) abort_bits = nbits;
            frame_since_rel = 0;
            hi_run = 0;
        end else begin
            e++;
            if (p_csb && !adc_csb) begin
                if (frame_since_rel) gaps.push_back(hi_run + 1);
                fall_cyc.push_back(e - 1);
                cur = '0; nbits = 0; last_rise = -1;
            end
            if (!adc_csb && !p_sclk && adc_sclk) begin
                cur = {cur[22:0], adc_sdio_o};
                nbits++;
                if (last_rise >= 0 && e - last_rise != 2 * CLK_DIV) bad_period++;
                last_rise = e;
            end
            if (adc_sclk && adc_sdio_o !== p_sdio) bad_sdio++;
            if (p_oe && !adc_sdio_oe && !adc_csb) oe_drop.push_back(nbits);
            if (!p_csb && adc_csb) begin
                obs_frame.push_back(cur);
                obs_bits.push_back(nbits);
                frame_since_rel = 1;
                hi_run = 0;
            end else if (adc_csb) begin
                hi_run++;
            end
            if (wr_ack) begin
                ack_cnt++;
                if (!init_done) early_ack++;
            end
            if (init_done && !p_done) begin
                done_seen   = 1;
                done_frames = obs_frame.size();
                done_gap    = hi_run;
            end
        end
        p_csb = adc_csb; p_sclk = adc_sclk; p_sdio = adc_sdio_o;
        p_oe = adc_sdio_oe; p_done = init_done;
    end

    // ---------------- reference model ----------------------------------
    function automatic logic [23:0] make_frame(input logic rw, input logic [12:0] a,
                                               input logic [7:0] d);
        return {rw, 2'b00, a, d};
    endfunction

    logic [23:0] exp_q[$];
    bit          exp_err;

    task automatic build_init_model();
        logic [12:0] ta[4];
        logic [7:0]  td[4];
        ta = '{13'h000, 13'h014, 13'h00D, 13'h0FF};
        td = '{8'h3C, 8'h01, 8'h00, 8'h01};
        exp_q.delete();
        exp_err = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(make_frame(1'b0, ta[i], td[i]));
            if (RB && ta[i] != 13'h000 && ta[i] != 13'h0FF) begin
                exp_q.push_back(make_frame(1'b1, ta[i], 8'h00));
                if (td[i] != 8'h00) exp_err = 1;   // pad model returns 0x00
            end
        end
    endtask

    // ---------------- helpers (waiting only) ---------------------------
    task automatic clear_mon();
        obs_frame.delete(); obs_bits.delete(); fall_cyc.delete();
        gaps.delete(); oe_drop.delete();
        bad_period = 0; bad_sdio = 0; early_ack = 0; ack_cnt = 0;
        done_seen = 0; abort_bits = -1; rst_rises = 0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit to);
        int c;
        c = 0;
        while (obs_frame.size() < n && c < budget) begin
            @(negedge clk_200m); #1; c++;
        end
        to = (obs_frame.size() < n);
    endtask

    task automatic wait_ack(input int budget, output bit to);
        int c;
        c = 0;
        while (!wr_ack && c < budget) begin
            @(negedge clk_200m); #1; c++;
        end
        to = !wr_ack;
    endtask

    // ---------------- tests --------------------------------------------
    task automatic test_reset();
        logic [7:0] got;
        wr_req = 1; wr_addr = 13'h018; wr_data = 8'h04;
        rst_n = 0;
        repeat (3) @(negedge clk_200m);
        #1;
        got = {wr_ack, init_done, busy, cfg_err, adc_csb, adc_sclk, adc_sdio_o, adc_sdio_oe};
        checks++;
        if (got !== 8'b0010_1000) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", got, 8'b0010_1000);
        end
        clear_mon();
        @(negedge clk_200m); #1 rst_n = 1;
    endtask

    task automatic test_init_and_held_req();
        bit to;
        int n, bad_gap;
        build_init_model();
        n = exp_q.size();
        wait_frames(1, 3000, to);
        checks++;
        if (to || fall_cyc.size() == 0 || fall_cyc[0] < 101 || fall_cyc[0] > 103) begin
            errors++; $display("FAIL first_csb_fall: got %0d expected 102+-1 (timeout=%0d)",
                               fall_cyc.size() ? fall_cyc[0] : -1, to);
        end
        checks++;
        if (to || obs_frame[0] !== 24'h00003C || obs_bits[0] != 24) begin
            errors++; $display("FAIL first_frame: got %h/%0d bits expected 00003c/24",
                               to ? 24'h0 : obs_frame[0], to ? 0 : obs_bits[0]);
        end
        while (!done_seen && e < 10000) begin @(negedge clk_200m); #1; end
        checks++;
        if (!done_seen || done_frames != n) begin
            errors++; $display("FAIL init_done_frames: got %0d (seen=%0d) expected %0d",
                               done_frames, done_seen, n);
        end
        checks++;
        if (done_gap < GAP_CYC) begin
            errors++; $display("FAIL init_done_gap: got %0d expected >= %0d", done_gap, GAP_CYC);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= obs_frame.size() || obs_frame[i] !== exp_q[i] || obs_bits[i] != 24) begin
                errors++; $display("FAIL init_frame%0d: got %h expected %h", i,
                                   i < obs_frame.size() ? obs_frame[i] : 24'hx, exp_q[i]);
            end
        end
        checks++;
        if (early_ack != 0) begin
            errors++; $display("FAIL early_ack: got %0d acks before init_done expected 0", early_ack);
        end
        checks++;
        if (cfg_err !== exp_err || busy !== 1'b0 && ack_cnt == 0) begin
            errors++; $display("FAIL cfg_err: got %b expected %b", cfg_err, exp_err);
        end
        checks++;
        if (RB ? (oe_drop.size() != 2 || oe_drop[0] != 16 || oe_drop[1] != 16)
               : (oe_drop.size() != 0)) begin
            errors++; $display("FAIL oe_release: got %0d mid-frame drops (first at %0d) expected %0d at 16",
                               oe_drop.size(), oe_drop.size() ? oe_drop[0] : -1, RB ? 2 : 0);
        end
        // held host request goes out after init, immune to later input changes
        wait_ack(200, to);
        wr_req = 0;
        wr_addr = 13'($urandom); wr_data = 8'hFF;
        wait_frames(n + 1, 1000, to);
        checks++;
        if (to || obs_frame[n] !== make_frame(1'b0, 13'h018, 8'h04)) begin
            errors++; $display("FAIL held_req_frame: got %h expected %h",
                               to ? 24'hx : obs_frame[n], make_frame(1'b0, 13'h018, 8'h04));
        end
        bad_gap = 0;
        foreach (gaps[i]) if (gaps[i] < GAP_CYC) bad_gap++;
        checks++;
        if (bad_gap != 0 || gaps.size() != n) begin
            errors++; $display("FAIL csb_gap: got %0d short of %0d gaps expected 0 short of %0d",
                               bad_gap, gaps.size(), n);
        end
    endtask

    task automatic test_random_writes();
        bit to;
        logic [12:0] a;
        logic [7:0]  d;
        int base;
        for (int k = 0; k < 6; k++) begin
            a = 13'($urandom); d = 8'($urandom);
            base = obs_frame.size();
            @(negedge clk_200m); #1;
            wr_addr = a; wr_data = d; wr_req = 1;
            wait_ack(500, to);
            wr_req = 0;
            wr_addr = 13'($urandom); wr_data = 8'($urandom);
            checks++;
            if (to) begin
                errors++; $display("FAIL rand_ack%0d: got no ack expected ack within 500 cycles", k);
            end
            wait_frames(base + 1, 1000, to);
            checks++;
            if (to || obs_frame[base] !== make_frame(1'b0, a, d) || obs_bits[base] != 24) begin
                errors++; $display("FAIL rand_frame%0d: got %h expected %h", k,
                                   to ? 24'hx : obs_frame[base], make_frame(1'b0, a, d));
            end
        end
        checks++;
        if (bad_period != 0 || bad_sdio != 0) begin
            errors++; $display("FAIL sclk_timing: got %0d period errors, %0d sdio changes at sclk high expected 0",
                               bad_period, bad_sdio);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int base, acks0;
        logic [12:0] a0, a1;
        logic [7:0]  d0, d1;
        a0 = 13'($urandom); d0 = 8'($urandom);
        a1 = 13'($urandom); d1 = 8'($urandom);
        base = obs_frame.size(); acks0 = ack_cnt;
        @(negedge clk_200m); #1;
        wr_addr = a0; wr_data = d0; wr_req = 1;
        wait_ack(500, to);
        wr_addr = a1; wr_data = d1;          // second request follows immediately
        @(negedge clk_200m); #1;
        wait_ack(1000, to);
        wr_req = 0;
        wait_frames(base + 2, 1000, to);
        checks++;
        if (to || obs_frame[base] !== make_frame(1'b0, a0, d0) ||
            obs_frame[base + 1] !== make_frame(1'b0, a1, d1)) begin
            errors++; $display("FAIL b2b_frames: got %h %h expected %h %h",
                               to ? 24'hx : obs_frame[base], to ? 24'hx : obs_frame[base + 1],
                               make_frame(1'b0, a0, d0), make_frame(1'b0, a1, d1));
        end
        checks++;
        if (ack_cnt - acks0 != 2) begin
            errors++; $display("FAIL b2b_acks: got %0d expected 2", ack_cnt - acks0);
        end
        checks++;
        if (gaps.size() == 0 || gaps[gaps.size() - 1] < GAP_CYC) begin
            errors++; $display("FAIL b2b_gap: got %0d expected >= %0d",
                               gaps.size() ? gaps[gaps.size() - 1] : -1, GAP_CYC);
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        int c;
        rst_n = 0;
        repeat (3) @(negedge clk_200m);
        clear_mon();
        #1 rst_n = 1;
        c = 0;
        while (!(obs_frame.size() == 1 && !adc_csb && nbits == 10) && c < 3000) begin
            @(negedge clk_200m); #1; c++;
        end
        checks++;
        if (c >= 3000) begin
            errors++; $display("FAIL mid_reset_reach: got no bit 10 of frame 2 expected within 3000 cycles");
        end
        rst_n = 0;
        #1;
        checks++;
        if (adc_csb !== 1'b1 || adc_sclk !== 1'b0 || adc_sdio_oe !== 1'b0) begin
            errors++; $display("FAIL mid_reset_abort: got csb=%b sclk=%b oe=%b expected 1 0 0",
                               adc_csb, adc_sclk, adc_sdio_oe);
        end
        repeat (10) @(negedge clk_200m);
        #1;
        checks++;
        if (rst_rises != 0 || abort_bits != 10 || adc_csb !== 1'b1) begin
            errors++; $display("FAIL mid_reset_quiet: got %0d sclk rises, abort at bit %0d expected 0, 10",
                               rst_rises, abort_bits);
        end
        clear_mon();
        @(negedge clk_200m); #1 rst_n = 1;
        wait_frames(1, 3000, to);
        checks++;
        if (to || obs_frame[0] !== 24'h00003C || fall_cyc[0] < 101 || fall_cyc[0] > 103) begin
            errors++; $display("FAIL mid_reset_restart: got %h at cycle %0d expected 00003c at 102+-1",
                               to ? 24'hx : obs_frame[0], fall_cyc.size() ? fall_cyc[0] : -1);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_and_held_req();
        test_random_writes();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
